// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection, EX bubble insertion
// and a WB->ID register-file bypass on the captured operands.
module id_ex_stage #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AOPW = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            valid_ID,
    input  logic [DW-1:0]   pc_ID,
    input  logic [4:0]      rf_raddr0_ID,
    input  logic [4:0]      rf_raddr1_ID,
    input  logic            use_rs_ID,
    input  logic            use_rt_ID,
    input  logic [DW-1:0]   rf_rdata0_ID,
    input  logic [DW-1:0]   rf_rdata1_ID,
    input  logic [DW-1:0]   imm_ID,
    input  logic [AOPW-1:0] alu_op_ID,
    input  logic            rf_wen_ID,
    input  logic [4:0]      rf_waddr_ID,
    input  logic            mem_ren_ID,
    input  logic            mem_wen_ID,
    input  logic            rf_wen_WB,
    input  logic [4:0]      rf_waddr_WB,
    input  logic [DW-1:0]   rf_wdata_WB,
    output logic            valid_EX,
    output logic [DW-1:0]   pc_EX,
    output logic [4:0]      rf_raddr0_EX,
    output logic [4:0]      rf_raddr1_EX,
    output logic [DW-1:0]   rf_rdata0_EX,
    output logic [DW-1:0]   rf_rdata1_EX,
    output logic [DW-1:0]   imm_EX,
    output logic [AOPW-1:0] alu_op_EX,
    output logic            rf_wen_EX,
    output logic [4:0]      rf_waddr_EX,
    output logic            mem_ren_EX,
    output logic            mem_wen_EX,
    output logic            load_use_stall,
    output logic [CNTW-1:0] bubble_cnt
);

    logic hazard;
    logic byp0;
    logic byp1;

    always_comb begin
        hazard = valid_EX && mem_ren_EX && rf_wen_EX && (rf_waddr_EX != '0) && valid_ID &&
                 ((use_rs_ID && (rf_raddr0_ID == rf_waddr_EX)) ||
                  (use_rt_ID && (rf_raddr1_ID == rf_waddr_EX)));
        load_use_stall = hazard && !flush_in;
        byp0 = rf_wen_WB && (rf_waddr_WB != '0) && (rf_waddr_WB == rf_raddr0_ID);
        byp1 = rf_wen_WB && (rf_waddr_WB != '0) && (rf_waddr_WB == rf_raddr1_ID);
    end

    // Bubbles clear only control/address fields; pc, data, imm and alu_op keep prior values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_EX     <= 1'b0;
            pc_EX        <= '0;
            rf_raddr0_EX <= '0;
            rf_raddr1_EX <= '0;
            rf_rdata0_EX <= '0;
            rf_rdata1_EX <= '0;
            imm_EX       <= '0;
            alu_op_EX    <= '0;
            rf_wen_EX    <= 1'b0;
            rf_waddr_EX  <= '0;
            mem_ren_EX   <= 1'b0;
            mem_wen_EX   <= 1'b0;
            bubble_cnt   <= '0;
        end else if (flush_in || (!stall_in && (hazard || !valid_ID))) begin
            valid_EX     <= 1'b0;
            rf_raddr0_EX <= '0;
            rf_raddr1_EX <= '0;
            rf_wen_EX    <= 1'b0;
            rf_waddr_EX  <= '0;
            mem_ren_EX   <= 1'b0;
            mem_wen_EX   <= 1'b0;
            if (!flush_in && hazard && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNTW'(1);
        end else if (!stall_in) begin
            valid_EX     <= 1'b1;
            pc_EX        <= pc_ID;
            rf_raddr0_EX <= rf_raddr0_ID;
            rf_raddr1_EX <= rf_raddr1_ID;
            rf_rdata0_EX <= byp0 ? rf_wdata_WB : rf_rdata0_ID;
            rf_rdata1_EX <= byp1 ? rf_wdata_WB : rf_rdata1_ID;
            imm_EX       <= imm_ID;
            alu_op_EX    <= alu_op_ID;
            rf_wen_EX    <= rf_wen_ID && (rf_waddr_ID != '0);
            rf_waddr_EX  <= rf_waddr_ID;
            mem_ren_EX   <= mem_ren_ID;
            mem_wen_EX   <= mem_wen_ID;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: expected EX states are queued
// as each ID instruction is driven and compared one cycle later.
module tb_id_ex_stage;

    localparam int unsigned DW   = 32;
    localparam int unsigned AOPW = 4;
    localparam int unsigned CNTW = 8;

    typedef struct packed {
        logic            valid;
        logic [DW-1:0]   pc;
        logic [4:0]      ra0;
        logic [4:0]      ra1;
        logic [DW-1:0]   d0;
        logic [DW-1:0]   d1;
        logic [DW-1:0]   imm;
        logic [AOPW-1:0] op;
        logic            rfwen;
        logic [4:0]      waddr;
        logic            ren;
        logic            mwen;
        logic [CNTW-1:0] cnt;
    } ex_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall_in, flush_in, valid_ID;
    logic [DW-1:0]   pc_ID;
    logic [4:0]      rf_raddr0_ID, rf_raddr1_ID;
    logic            use_rs_ID, use_rt_ID;
    logic [DW-1:0]   rf_rdata0_ID, rf_rdata1_ID, imm_ID;
    logic [AOPW-1:0] alu_op_ID;
    logic            rf_wen_ID;
    logic [4:0]      rf_waddr_ID;
    logic            mem_ren_ID, mem_wen_ID;
    logic            rf_wen_WB;
    logic [4:0]      rf_waddr_WB;
    logic [DW-1:0]   rf_wdata_WB;
    logic            valid_EX;
    logic [DW-1:0]   pc_EX;
    logic [4:0]      rf_raddr0_EX, rf_raddr1_EX;
    logic [DW-1:0]   rf_rdata0_EX, rf_rdata1_EX, imm_EX;
    logic [AOPW-1:0] alu_op_EX;
    logic            rf_wen_EX;
    logic [4:0]      rf_waddr_EX;
    logic            mem_ren_EX, mem_wen_EX;
    logic            load_use_stall;
    logic [CNTW-1:0] bubble_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    ex_t  cur;
    int   m_cnt;
    ex_t  exp_q[$];

    always #5 clk = ~clk;

    // Narrow counter so saturation is reachable in a short run.
    id_ex_stage #(.DW(DW), .AOPW(AOPW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
        .valid_ID(valid_ID), .pc_ID(pc_ID), .rf_raddr0_ID(rf_raddr0_ID),
        .rf_raddr1_ID(rf_raddr1_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
        .rf_rdata0_ID(rf_rdata0_ID), .rf_rdata1_ID(rf_rdata1_ID), .imm_ID(imm_ID),
        .alu_op_ID(alu_op_ID), .rf_wen_ID(rf_wen_ID), .rf_waddr_ID(rf_waddr_ID),
        .mem_ren_ID(mem_ren_ID), .mem_wen_ID(mem_wen_ID), .rf_wen_WB(rf_wen_WB),
        .rf_waddr_WB(rf_waddr_WB), .rf_wdata_WB(rf_wdata_WB), .valid_EX(valid_EX),
        .pc_EX(pc_EX), .rf_raddr0_EX(rf_raddr0_EX), .rf_raddr1_EX(rf_raddr1_EX),
        .rf_rdata0_EX(rf_rdata0_EX), .rf_rdata1_EX(rf_rdata1_EX), .imm_EX(imm_EX),
        .alu_op_EX(alu_op_EX), .rf_wen_EX(rf_wen_EX), .rf_waddr_EX(rf_waddr_EX),
        .mem_ren_EX(mem_ren_EX), .mem_wen_EX(mem_wen_EX),
        .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input ex_t e);
        chk({tag, ".valid"}, 64'(valid_EX), 64'(e.valid));
        chk({tag, ".pc"}, 64'(pc_EX), 64'(e.pc));
        chk({tag, ".ra0"}, 64'(rf_raddr0_EX), 64'(e.ra0));
        chk({tag, ".ra1"}, 64'(rf_raddr1_EX), 64'(e.ra1));
        chk({tag, ".d0"}, 64'(rf_rdata0_EX), 64'(e.d0));
        chk({tag, ".d1"}, 64'(rf_rdata1_EX), 64'(e.d1));
        chk({tag, ".imm"}, 64'(imm_EX), 64'(e.imm));
        chk({tag, ".op"}, 64'(alu_op_EX), 64'(e.op));
        chk({tag, ".rf_wen"}, 64'(rf_wen_EX), 64'(e.rfwen));
        chk({tag, ".waddr"}, 64'(rf_waddr_EX), 64'(e.waddr));
        chk({tag, ".mem_ren"}, 64'(mem_ren_EX), 64'(e.ren));
        chk({tag, ".mem_wen"}, 64'(mem_wen_EX), 64'(e.mwen));
        chk({tag, ".cnt"}, 64'(bubble_cnt), 64'(e.cnt));
    endtask

    task automatic push(input ex_t e);
        exp_q.push_back(e);
        cur = e;
    endtask

    function automatic ex_t as_bubble(input ex_t e);
        ex_t b = e;
        b.valid = 1'b0; b.ra0 = '0; b.ra1 = '0; b.rfwen = 1'b0;
        b.waddr = '0;   b.ren = 1'b0; b.mwen = 1'b0;
        return b;
    endfunction

    task automatic exp_load();
        ex_t e = cur;
        if (!valid_ID) begin
            e = as_bubble(cur);
        end else begin
            e.valid = 1'b1;
            e.pc    = pc_ID;
            e.ra0   = rf_raddr0_ID;
            e.ra1   = rf_raddr1_ID;
            e.d0    = (rf_wen_WB && rf_waddr_WB != 0 && rf_waddr_WB == rf_raddr0_ID) ? rf_wdata_WB : rf_rdata0_ID;
            e.d1    = (rf_wen_WB && rf_waddr_WB != 0 && rf_waddr_WB == rf_raddr1_ID) ? rf_wdata_WB : rf_rdata1_ID;
            e.imm   = imm_ID;
            e.op    = alu_op_ID;
            e.rfwen = rf_wen_ID && (rf_waddr_ID != 0);
            e.waddr = rf_waddr_ID;
            e.ren   = mem_ren_ID;
            e.mwen  = mem_wen_ID;
        end
        e.cnt = CNTW'(m_cnt);
        push(e);
    endtask

    task automatic exp_bubble(input bit counted);
        ex_t e;
        if (counted && m_cnt < (1 << CNTW) - 1) m_cnt++;
        e = as_bubble(cur);
        e.cnt = CNTW'(m_cnt);
        push(e);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end
        if (exp_q.size() != 0) cmp(tag, exp_q.pop_front());
    endtask

    task automatic set_id(input logic v, input logic [DW-1:0] pc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic urs, input logic urt,
                          input logic [4:0] wa, input logic wen, input logic ren,
                          input logic mwen);
        valid_ID = v; pc_ID = pc; rf_raddr0_ID = rs; rf_raddr1_ID = rt;
        use_rs_ID = urs; use_rt_ID = urt; rf_waddr_ID = wa; rf_wen_ID = wen;
        mem_ren_ID = ren; mem_wen_ID = mwen;
        rf_rdata0_ID = pc ^ 32'hA5A5_0000; rf_rdata1_ID = pc ^ 32'h0000_5A5A;
        imm_ID = pc + 32'h10; alu_op_ID = pc[5:2];
    endtask

    initial begin
        rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        rf_wen_WB = 1'b0; rf_waddr_WB = '0; rf_wdata_WB = '0;
        set_id(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cur = '0; m_cnt = 0;
        #2;
        cmp("reset", '0);
        chk("reset.lus", 64'(load_use_stall), 64'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;

        // lw $5 then dependent add: one bubble
        set_id(1'b1, 32'h100, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        exp_load(); tick("lw5");
        set_id(1'b1, 32'h104, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("lu.stall", 64'(load_use_stall), 64'd1);
        exp_bubble(1'b1); tick("lu_bubble");
        chk("lu.stall_drop", 64'(load_use_stall), 64'd0);
        exp_load(); tick("lu_add");

        // lw $0 then use of $0: no hazard
        set_id(1'b1, 32'h108, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        exp_load(); tick("lw0");
        set_id(1'b1, 32'h10C, 5'd0, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1 chk("lw0.stall", 64'(load_use_stall), 64'd0);
        exp_load(); tick("use0");

        // lw $5 then addi with rt=$5 but use_rt=0
        set_id(1'b1, 32'h110, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        exp_load(); tick("lw5b");
        set_id(1'b1, 32'h114, 5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 chk("addi.stall", 64'(load_use_stall), 64'd0);
        exp_load(); tick("addi");

        // WB->ID bypass, then with WB address $0
        set_id(1'b1, 32'h118, 5'd9, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        rf_wen_WB = 1'b1; rf_waddr_WB = 5'd9; rf_wdata_WB = 32'hDEADBEEF;
        exp_load(); tick("byp9");
        chk("byp9.d0", 64'(rf_rdata0_EX), 64'hDEADBEEF);
        set_id(1'b1, 32'h11C, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        rf_waddr_WB = 5'd0;
        exp_load(); tick("byp0");
        set_id(1'b1, 32'h120, 5'd4, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
        rf_waddr_WB = 5'd9;
        exp_load(); tick("byp9_rt");
        rf_wen_WB = 1'b0;

        // flush together with hazard
        set_id(1'b1, 32'h200, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        exp_load(); tick("lw5c");
        set_id(1'b1, 32'h204, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        flush_in = 1'b1;
        #1 chk("flush.stall", 64'(load_use_stall), 64'd0);
        exp_bubble(1'b0); tick("flush");
        flush_in = 1'b0;
        set_id(1'b1, 32'h208, 5'd2, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        exp_load(); tick("post_flush");

        // downstream stall for 3 cycles, then release
        set_id(1'b1, 32'h300, 5'd12, 5'd13, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(cur); tick("stall_hold");
        end
        stall_in = 1'b0;
        exp_load(); tick("stall_release");

        // hazard under stall: hold, stall output stays high
        set_id(1'b1, 32'h310, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        exp_load(); tick("lw5d");
        set_id(1'b1, 32'h314, 5'd0, 5'd5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        stall_in = 1'b1;
        #1 chk("hz_stall.lus", 64'(load_use_stall), 64'd1);
        push(cur); tick("hz_stall_hold");
        chk("hz_stall.lus2", 64'(load_use_stall), 64'd1);
        stall_in = 1'b0;
        exp_bubble(1'b1); tick("hz_after_stall");
        exp_load(); tick("hz_dep_load");

        // self-dependent loads drive the counter to saturation
        for (int i = 0; i < 260; i++) begin
            set_id(1'b1, 32'h1000 + 32'(i * 4), 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
            exp_load(); tick("sat_lw");
            exp_bubble(1'b1); tick("sat_bubble");
        end
        chk("sat.cnt", 64'(bubble_cnt), 64'hFF);

        // async reset mid-run with a hazard pending
        set_id(1'b1, 32'h400, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        exp_load(); tick("pre_rst_lw");
        set_id(1'b1, 32'h404, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("pre_rst.lus", 64'(load_use_stall), 64'd1);
        #1 rst_n = 1'b0;
        #1 cmp("async_rst", '0);
        chk("async_rst.lus", 64'(load_use_stall), 64'd0);
        cur = '0; m_cnt = 0;
        #2 rst_n = 1'b1;
        exp_load(); tick("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
